mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Responder end of the fetch/memory interface: byte-addressed, little-endian RAM window at BASEADDR
//  that answers reads (addr_i/read_en_i -> data_o) and services sized stores. With READ_LATENCY=0 it
//  drops straight onto fetch's mem_addr_o/mem_read_en_o/mem_data_i; READ_LATENCY=1 models a
//  registered SRAM. Optional post-reset zeroing sweep.
// PARAMETERS
//  DWIDTH        32            data width (fixed 32; 4 bytes per access)
//  AWIDTH        32            address width
//  BASEADDR      32'h01000000  byte address of mem[0]
//  MEM_BYTES     65536         window size in bytes; power of two, multiple of 4
//  READ_LATENCY  0             0 = combinational read, 1 = registered read
//  CLEAR_ON_RST  0             1 = zero whole array after reset, one word per cycle
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, asynchronous, active-high
//  addr_i       in   AWIDTH  byte address, shared by read and write
//  read_en_i    in   1       read request
//  data_o       out  DWIDTH  read data
//  data_valid_o out  1       data_o valid for the request made READ_LATENCY cycles earlier
//  write_en_i   in   1       store request
//  wdata_i      in   DWIDTH  store data, LSB-aligned
//  size_i       in   2       00 byte, 01 half, 10 word, 11 reserved
//  err_o        out  1       current request out of range / misaligned / reserved size
//  ready_o      out  1       0 while clearing; requests ignored when 0
// BEHAVIOUR
//  - Reset values: data_o=0, data_valid_o=0, err_o=0; ready_o=0 if CLEAR_ON_RST else 1. Array contents
//    are untouched by rst itself.
//  - Translation: off = addr_i - BASEADDR (AWIDTH modular); in range iff off < MEM_BYTES.
//  - Read: data_o = {mem[off+3],mem[off+2],mem[off+1],mem[off]}; any byte beyond the window reads 0;
//    off fully out of range -> data_o=0, err_o=1. Reads may be unaligned.
//  - Latency 0: data_o/err_o combinational, data_valid_o = read_en_i & ready_o.
//    Latency 1: data_o, err_o, data_valid_o registered at the posedge that samples read_en_i. When
//    read_en_i=0, data_o holds its last value and data_valid_o=0.
//  - Write at posedge when write_en_i & ready_o & ~err: byte writes wdata_i[7:0] at off;
//    half writes [15:0] at off..off+1; word writes [31:0] at off..off+3.
//  - Write error (suppresses write): out of range, any written byte beyond the window, half with off[0]=1,
//    word with off[1:0]!=0, size_i=11. Latency 0: err_o combinational. Latency 1: err_o registered.
//  - Same-cycle read and write to overlapping bytes: read returns the pre-write data (read-before-write).
//  - FSM {CLEAR, READY}. If CLEAR_ON_RST=1, rst enters CLEAR with clr_ptr=0. Each cycle writes a zero word
//    at clr_ptr and increments it by 4. After MEM_BYTES/4 cycles it goes to READY (ready_o=1 the next cycle).
//    In CLEAR: data_o=0, data_valid_o=0, err_o=0, writes dropped. If CLEAR_ON_RST=0, the FSM stays in READY.
//  - rst asserted mid-sweep or mid-access: clr_ptr and output registers clear immediately. The sweep
//    restarts from 0. A partially cleared array is fully cleared by the restarted sweep.
//  - clr_ptr is log2(MEM_BYTES)+1 bits wide, with no wrap past the end.
// STRUCTURE
//  - mem_pkg: typedef enum logic[1:0] mem_size_e {MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10};
//    typedef enum logic mem_state_e {ST_CLEAR, ST_READY}; localparam WORD_BYTES=4.
//  - Sub-module mem_addr_check: combinational; inputs addr, size, is_write; outputs off, in_range,
//    misaligned, err. Its err feeds both the read and write paths.
//  - Byte array logic [7:0] mem [MEM_BYTES]. Optional $readmemh preload via plusarg, done in the bench only.
// TESTING
//  1 Latency 0, 4 GiB-minus-window (off-window): read addr 32'h00FFFFFC -> data_o=0, err_o=1.
//  2 Word store 32'hDEADBEEF @01000000, then read 01000000 -> DEADBEEF; read 01000001 -> 00DEADBE;
//    byte store 8'h11 @01000002, then read 01000000 -> DE11BEEF.
//  3 Half store @01000001 -> err_o=1, memory unchanged. size_i=11 -> err_o=1.
//    Word store @0100FFFE (MEM_BYTES=65536) -> err_o=1. Read 0100FFFE -> 0000xxxx with upper bytes 0, err_o=0.
//  4 Latency 1: read 01000000 in cycle n, store 32'h12345678 there in the same cycle ->
//    cycle n+1 data_o = old value, data_valid_o=1. Read again -> 12345678.
//  5 CLEAR_ON_RST=1, MEM_BYTES=64: preload nonzero, pulse rst -> ready_o=0 for 16 cycles, then 1.
//    All reads return 0. Reassert rst at cycle 7 -> count restarts; a write during CLEAR is dropped.
//  6 Integration with fetch (latency 0, preloaded image): insn_o sequence matches image words
//    at 01000000, 01000004, ...

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size and FSM types for the memory responder
package mem_pkg;
    typedef enum logic [1:0] {MEM_BYTE = 2'b00, MEM_HALF = 2'b01, MEM_WORD = 2'b10} mem_size_e;
    typedef enum logic {ST_CLEAR, ST_READY} mem_state_e;
    localparam int WORD_BYTES = 4;
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        return size == MEM_BYTE ? 3'd1 : size == MEM_HALF ? 3'd2 : size == MEM_WORD ? 3'd4 : 3'd0;
    endfunction
endpackage

// File: rtl/mem_addr_check.sv
// mem_addr_check: translates a byte address into a window offset and flags range/alignment errors
module mem_addr_check
    import mem_pkg::*;
#(
    parameter int                AWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASEADDR  = 32'h01000000,
    parameter int                MEM_BYTES = 65536
) (
    input  logic [AWIDTH-1:0] addr,
    input  logic [1:0]        size,
    input  logic              is_write,
    output logic [AWIDTH-1:0] off,
    output logic              in_range,
    output logic              misaligned,
    output logic              err
);
    localparam logic [AWIDTH:0] LIM = (AWIDTH+1)'(MEM_BYTES);
    logic [AWIDTH:0] w_end;
    assign off        = addr - BASEADDR;
    assign w_end      = {1'b0, off} + {{(AWIDTH-2){1'b0}}, size_bytes(size)};
    assign in_range   = {1'b0, off} < LIM;
    assign misaligned = (size == MEM_HALF && off[0]) || (size == MEM_WORD && off[1:0] != 2'b00);
    // reads only fail when fully outside; stores must fit entirely and be naturally aligned
    assign err        = !in_range || (is_write && (w_end > LIM || misaligned || size == 2'b11));
endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte-addressed little-endian RAM window answering reads and sized stores,
// with selectable read latency and an optional post-reset zeroing sweep.
module mem_responder
    import mem_pkg::*;
#(
    parameter int                DWIDTH       = 32,
    parameter int                AWIDTH       = 32,
    parameter logic [AWIDTH-1:0] BASEADDR     = 32'h01000000,
    parameter int                MEM_BYTES    = 65536,
    parameter int                READ_LATENCY = 0,
    parameter int                CLEAR_ON_RST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic              read_en_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              data_valid_o,
    input  logic              write_en_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [1:0]        size_i,
    output logic              err_o,
    output logic              ready_o
);
    localparam int            IW   = $clog2(MEM_BYTES);
    localparam logic [IW:0]   LAST = (IW+1)'(MEM_BYTES - WORD_BYTES);

    logic [7:0]        mem [MEM_BYTES];
    mem_state_e        r_state, w_state_nx;
    logic [IW:0]       r_clr_ptr, w_clr_ptr_nx;
    logic [AWIDTH-1:0] w_off;
    logic [IW-1:0]     w_idx;
    logic [2:0]        w_nbytes;
    logic              w_in_range, w_misaligned, w_err, w_ready, w_wr_ok;
    logic [DWIDTH-1:0] w_rdata, r_data;
    logic              r_dv, r_err;

    mem_addr_check #(
        .AWIDTH   (AWIDTH),
        .BASEADDR (BASEADDR),
        .MEM_BYTES(MEM_BYTES)
    ) u_check (
        .addr      (addr_i),
        .size      (size_i),
        .is_write  (write_en_i),
        .off       (w_off),
        .in_range  (w_in_range),
        .misaligned(w_misaligned),
        .err       (w_err)
    );

    assign w_idx    = w_off[IW-1:0];
    assign w_nbytes = size_bytes(size_i);
    assign w_ready  = r_state == ST_READY;
    assign w_wr_ok  = w_ready && write_en_i && w_in_range && !w_misaligned && !w_err;

    // bytes that fall past the end of the window read as zero
    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < WORD_BYTES; k++)
            if (w_in_range && {1'b0, w_off} + (AWIDTH+1)'(k) < (AWIDTH+1)'(MEM_BYTES))
                w_rdata[8*k +: 8] = mem[w_idx + IW'(k)];
    end

    // no reset on the array: only the sweep or a store changes contents
    always_ff @(posedge clk) begin
        if (!w_ready) begin
            for (int k = 0; k < WORD_BYTES; k++)
                mem[r_clr_ptr[IW-1:0] + IW'(k)] <= '0;
        end else if (w_wr_ok) begin
            for (int k = 0; k < WORD_BYTES; k++)
                if (3'(k) < w_nbytes)
                    mem[w_idx + IW'(k)] <= wdata_i[8*k +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= CLEAR_ON_RST != 0 ? ST_CLEAR : ST_READY;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_clr_ptr <= w_clr_ptr_nx;
        end
    end

    always_comb begin
        w_clr_ptr_nx = r_state == ST_CLEAR ? r_clr_ptr + (IW+1)'(WORD_BYTES) : r_clr_ptr;
        w_state_nx   = (r_state == ST_CLEAR && r_clr_ptr != LAST) ? ST_CLEAR : ST_READY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_dv   <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_data <= !w_ready ? '0 : read_en_i ? w_rdata : r_data;
            r_dv   <= w_ready && read_en_i;
            r_err  <= w_ready && (read_en_i || write_en_i) && w_err;
        end
    end

    assign data_o       = READ_LATENCY != 0 ? r_data : (w_ready ? w_rdata : '0);
    assign data_valid_o = READ_LATENCY != 0 ? r_dv : (w_ready && read_en_i);
    assign err_o        = READ_LATENCY != 0 ? r_err : (w_ready && (read_en_i || write_en_i) && w_err);
    assign ready_o      = w_ready;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder against a byte-map reference model
module tb_mem_responder;
    localparam logic [31:0] BASE = 32'h01000000;

    logic        clk = 0, rst = 1, rst2 = 1;
    logic [31:0] addr = 0, wdata = 0;
    logic [1:0]  size = 0;
    logic        re = 0, we = 0, re2 = 0, we2 = 0;
    logic [31:0] d0, d1, d2;
    logic        v0, v1, v2, e0, e1, e2, r0, r1, r2;

    always #5 clk = ~clk;

    mem_responder #(.READ_LATENCY(0)) u0 (
        .clk(clk), .rst(rst), .addr_i(addr), .read_en_i(re), .data_o(d0), .data_valid_o(v0),
        .write_en_i(we), .wdata_i(wdata), .size_i(size), .err_o(e0), .ready_o(r0));
    mem_responder #(.READ_LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .addr_i(addr), .read_en_i(re), .data_o(d1), .data_valid_o(v1),
        .write_en_i(we), .wdata_i(wdata), .size_i(size), .err_o(e1), .ready_o(r1));
    mem_responder #(.MEM_BYTES(64), .CLEAR_ON_RST(1)) u2 (
        .clk(clk), .rst(rst2), .addr_i(addr), .read_en_i(re2), .data_o(d2), .data_valid_o(v2),
        .write_en_i(we2), .wdata_i(wdata), .size_i(size), .err_o(e2), .ready_o(r2));

    typedef struct {logic [31:0] d; logic e; logic v;} exp_t;
    exp_t q0[$], q1[$], q2[$];
    logic [7:0] mm [longint];
    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic longint key(input int inst, input longint off);
        return longint'(inst) * 64'h1_0000_0000 + off;
    endfunction

    function automatic logic [7:0] mbyte(input int inst, input longint off);
        return mm.exists(key(inst, off)) ? mm[key(inst, off)] : 8'h00;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic werr(input logic [31:0] off, input logic [1:0] sz, input longint mb);
        return longint'(off) >= mb || sz == 2'b11 || (sz == 2'b01 && off[0]) ||
               (sz == 2'b10 && off[1:0] != 2'b00) || longint'(off) + nbytes(sz) > mb;
    endfunction

    // one request for one cycle; expected response is computed from the model before the store lands
    task automatic issue(input int inst, input logic [31:0] a, input logic rd, input logic wr,
                         input logic [31:0] wd, input logic [1:0] sz);
        longint mb;
        logic [31:0] off;
        exp_t x;
        mb  = inst == 2 ? 64 : 65536;
        off = a - BASE;
        x.d = 0;
        x.v = rd;
        x.e = (rd && longint'(off) >= mb) || (wr && werr(off, sz, mb));
        if (longint'(off) < mb)
            for (int k = 0; k < 4; k++)
                if (longint'(off) + k < mb) x.d[8*k +: 8] = mbyte(inst, longint'(off) + k);
        if (rd || x.e) begin
            if (inst == 2) q2.push_back(x);
            else begin q0.push_back(x); q1.push_back(x); end
        end
        if (wr && !werr(off, sz, mb))
            for (int k = 0; k < nbytes(sz); k++) mm[key(inst, longint'(off) + k)] = wd[8*k +: 8];
        addr = a; wdata = wd; size = sz;
        if (inst == 2) begin re2 = rd; we2 = wr; end
        else begin re = rd; we = wr; end
        @(posedge clk); #1;
        re = 0; we = 0; re2 = 0; we2 = 0;
    endtask

    task automatic cmp(input string nm, input logic v, input logic [31:0] d, input logic e, input exp_t x);
        chk({nm, "_valid"}, v, x.v);
        chk({nm, "_err"}, e, x.e);
        if (x.v) chk({nm, "_data"}, d, x.d);
    endtask

    always @(negedge clk) if (v0 || e0) begin
        if (q0.size() == 0) begin checks++; failures++; $display("FAIL u0_unexpected valid=%b err=%b expected none", v0, e0); end
        else cmp("u0", v0, d0, e0, q0.pop_front());
    end
    always @(negedge clk) if (v1 || e1) begin
        if (q1.size() == 0) begin checks++; failures++; $display("FAIL u1_unexpected valid=%b err=%b expected none", v1, e1); end
        else cmp("u1", v1, d1, e1, q1.pop_front());
    end
    always @(negedge clk) if (v2 || e2) begin
        if (q2.size() == 0) begin checks++; failures++; $display("FAIL u2_unexpected valid=%b err=%b expected none", v2, e2); end
        else cmp("u2", v2, d2, e2, q2.pop_front());
    end

    task automatic wait_ready(output int n);
        n = 0;
        while (!r2 && n < 200) begin @(posedge clk); #1; n++; end
    endtask

    task automatic clr_model();
        for (int o = 0; o < 64; o++) mm[key(2, o)] = 8'h00;
    endtask

    task automatic pulse_rst2();
        rst2 = 1;
        @(posedge clk); #1;
        chk("clr_ready_in_rst", r2, 0);
        rst2 = 0;
    endtask

    function automatic logic [31:0] rnd_addr();
        int r = $urandom_range(0, 9);
        return r < 6 ? BASE + $urandom_range(0, 60) : r < 8 ? BASE + 65536 - 16 + $urandom_range(0, 15) :
               r == 8 ? BASE - $urandom_range(1, 4) : BASE + 65536 + $urandom_range(0, 7);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_d0", d0, 0); chk("rst_d1", d1, 0); chk("rst_d2", d2, 0);
        chk("rst_v1", v1, 0); chk("rst_e1", e1, 0);
        chk("rst_rdy0", r0, 1); chk("rst_rdy1", r1, 1); chk("rst_rdy2", r2, 0);
        rst = 0;
        for (int o = 0; o < 64; o += 4) issue(0, BASE + o, 0, 1, $urandom, 2'b10);
        for (int o = 65536 - 16; o < 65536; o += 4) issue(0, BASE + o, 0, 1, $urandom, 2'b10);
        issue(0, 32'h00FFFFFC, 1, 0, 0, 2'b10);
        issue(0, BASE, 0, 1, 32'hDEADBEEF, 2'b10);
        issue(0, BASE, 1, 0, 0, 2'b10);
        issue(0, BASE + 1, 1, 0, 0, 2'b10);
        issue(0, BASE + 2, 0, 1, 32'h00000011, 2'b00);
        issue(0, BASE, 1, 0, 0, 2'b10);
        issue(0, BASE + 1, 0, 1, 32'h0000CAFE, 2'b01);
        issue(0, BASE, 1, 0, 0, 2'b10);
        issue(0, BASE + 4, 0, 1, 32'h55555555, 2'b11);
        issue(0, BASE + 32'hFFFE, 0, 1, 32'h77777777, 2'b10);
        issue(0, BASE + 32'hFFFE, 1, 0, 0, 2'b10);
        issue(0, BASE + 32'hFFFE, 0, 1, 32'h0000ABCD, 2'b01);
        issue(0, BASE + 32'hFFFF, 0, 1, 32'h000000EE, 2'b00);
        issue(0, BASE + 32'hFFFC, 1, 0, 0, 2'b10);
        issue(0, BASE, 1, 1, 32'h12345678, 2'b10);
        issue(0, BASE, 1, 0, 0, 2'b10);
        for (int i = 0; i < 400; i++)
            issue(0, rnd_addr(), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom,
                  2'($urandom_range(0, 3)));
        repeat (3) @(posedge clk);
        #1;
        rst2 = 0;
        wait_ready(n);
        chk("clr_cycles_first", n, 16);
        clr_model();
        for (int o = 0; o < 64; o += 4) issue(2, BASE + o, 0, 1, $urandom | 32'h01010101, 2'b10);
        for (int o = 0; o < 64; o += 4) issue(2, BASE + o, 1, 0, 0, 2'b10);
        pulse_rst2();
        wait_ready(n);
        chk("clr_cycles_pulse", n, 16);
        clr_model();
        for (int o = 0; o < 64; o += 4) issue(2, BASE + o, 1, 0, 0, 2'b10);
        issue(2, BASE + 62, 1, 0, 0, 2'b10);
        for (int o = 0; o < 64; o += 4) issue(2, BASE + o, 0, 1, $urandom | 32'h01010101, 2'b10);
        pulse_rst2();
        repeat (7) @(posedge clk);
        #1;
        chk("clr_ready_mid_sweep", r2, 0);
        pulse_rst2();
        n = 0;
        while (!r2 && n < 200) begin
            if (n == 10) begin addr = BASE; wdata = 32'hA5A5A5A5; size = 2'b10; re2 = 1; we2 = 1; end
            @(posedge clk); #1;
            re2 = 0; we2 = 0;
            n++;
        end
        chk("clr_cycles_restart", n, 16);
        clr_model();
        for (int o = 0; o < 64; o += 4) issue(2, BASE + o, 1, 0, 0, 2'b10);
        repeat (3) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
